// File: rtl/sr_latch_bank_ctrl_if.sv
// Request/latch-bank bundle for sr_latch_bank_ctrl.
//   master : requesters plus latch bank (drives requests and q readback)
//   slave  : the controller (drives grants, latch s/r/e and status)
// Signals:
//   req_valid/req_op [N_REQ]      per-requester request and op (1=set, 0=reset)
//   req_idx [N_REQ*IDXW]          requester i uses bits [i*IDXW +: IDXW]
//   req_ready [N_REQ]             one-hot grant
//   latch_s/r/e [N_LATCH]         latch bank controls
//   latch_q [N_LATCH]             latch bank readback
//   busy, done, done_id, err      status
interface sr_latch_bank_ctrl_if #(
    parameter int N_LATCH = 4,
    parameter int N_REQ   = 2,
    parameter int IDXW    = $clog2(N_LATCH)
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_op;
    logic [N_REQ*IDXW-1:0] req_idx;
    logic [N_REQ-1:0]      req_ready;
    logic [N_LATCH-1:0]    latch_s;
    logic [N_LATCH-1:0]    latch_r;
    logic [N_LATCH-1:0]    latch_e;
    logic [N_LATCH-1:0]    latch_q;
    logic                  busy;
    logic                  done;
    logic [N_REQ-1:0]      done_id;
    logic                  err;

    modport master (
        output req_valid, req_op, req_idx, latch_q,
        input  req_ready, latch_s, latch_r, latch_e, busy, done, done_id, err
    );

    modport slave (
        input  req_valid, req_op, req_idx, latch_q,
        output req_ready, latch_s, latch_r, latch_e, busy, done, done_id, err
    );
endinterface

// File: rtl/sr_latch_bank_ctrl.sv
// Sequencing and round-robin arbitration controller for a bank of gated SR
// latches. One request at a time is granted, then the addressed latch gets
// s/r setup, an enable pulse and a hold cycle; q is read back at the end of
// hold and reported with done/err in the CHECK cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (aborts any operation)
//   bus  sr_latch_bank_ctrl_if.slave: requests, grants, latch bank, status
module sr_latch_bank_ctrl #(
    parameter int N_LATCH   = 4,
    parameter int N_REQ     = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int IDXW      = $clog2(N_LATCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_latch_bank_ctrl_if.slave  bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             op_q;
    logic [IDXW-1:0]  idx_q;
    logic [N_REQ-1:0] id_q;
    logic             err_q;

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic             grant;
    logic [N_LATCH-1:0] sel;
    logic             in_range;
    logic             q_bit;
    logic             drive_sr;

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        int unsigned ptr_u;
        int unsigned j;
        win_found = 1'b0;
        win_idx   = '0;
        ptr_u     = 32'(ptr_q);
        j         = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = (ptr_u + k) % N_REQ;
            if (!win_found && bus.req_valid[PW'(j)]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    assign grant = (state_q == ST_IDLE) && win_found;
    assign ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Decode of the captured index; an out-of-range index decodes to all-zero,
    // which keeps every latch line quiet for that request.
    always_comb begin
        sel = '0;
        for (int unsigned k = 0; k < N_LATCH; k++) begin
            sel[k] = (32'(idx_q) == k);
        end
    end

    assign in_range = (32'(idx_q) < 32'(N_LATCH));
    assign q_bit    = |(bus.latch_q & sel);

    // Phase sequencing; cnt counts cycles within SETUP and PULSE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == CW'(PULSE_CYC - 1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD:  state_d = ST_CHECK;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                ptr_q <= ptr_d;
                op_q  <= bus.req_op[win_idx];
                idx_q <= bus.req_idx[win_idx*IDXW +: IDXW];
                id_q  <= N_REQ'(1) << win_idx;
            end
            if (state_q == ST_HOLD) begin
                err_q <= !in_range || (q_bit != op_q);
            end
        end
    end

    assign drive_sr = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                      (state_q == ST_HOLD);

    assign bus.req_ready = grant ? (N_REQ'(1) << win_idx) : '0;
    assign bus.latch_s   = (drive_sr &&  op_q) ? sel : '0;
    assign bus.latch_r   = (drive_sr && !op_q) ? sel : '0;
    assign bus.latch_e   = (state_q == ST_PULSE) ? sel : '0;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_CHECK);
    assign bus.done_id   = (state_q == ST_CHECK) ? id_q : '0;
    assign bus.err       = (state_q == ST_CHECK) && err_q;

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Bench for sr_latch_bank_ctrl with N_LATCH=3 (so idx 3 is out of range),
// N_REQ=2, SETUP_CYC=1, PULSE_CYC=2. A transaction-level model predicts all
// outputs every cycle; directed sections pin it with literal expectations.
module tb_sr_latch_bank_ctrl;

    localparam int NL  = 3;
    localparam int NR  = 2;
    localparam int IW  = 2;
    localparam int S   = 1;
    localparam int P   = 2;
    localparam int LAT = S + P + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sr_latch_bank_ctrl_if #(.N_LATCH(NL), .N_REQ(NR), .IDXW(IW)) bus();

    sr_latch_bank_ctrl #(
        .N_LATCH(NL), .N_REQ(NR), .SETUP_CYC(S), .PULSE_CYC(P), .IDXW(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Gated SR latch bank with optional stuck-at-0 bits.
    logic [NL-1:0] lq = '0;
    logic [NL-1:0] stuck = '0;
    always @(posedge clk) begin
        if (rst) lq <= '0;
        else begin
            for (int k = 0; k < NL; k++) begin
                if (bus.latch_e[k]) begin
                    if (bus.latch_s[k]) lq[k] <= 1'b1;
                    else if (bus.latch_r[k]) lq[k] <= 1'b0;
                end
            end
        end
    end
    assign bus.latch_q = lq & ~stuck;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Transaction model: one outstanding operation with its grant cycle.
    int  cyc = 0;
    bit  model_ok = 0;
    bit  m_act = 0;
    int  m_g = 0, m_op = 0, m_idx = 0, m_id = 0, m_ptr = 0, m_q = 0;
    int  m_grants = 0;
    int  gq[$];
    int  dut_grants = 0, dut_dones = 0;
    logic [NR-1:0] rdy_seen = '0;

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_act = 0;
            m_ptr = 0;
            model_ok = 1;
            gq.delete();
        end else if (m_act) begin
            if (cyc - m_g == S + P + 1) m_q = (m_idx < NL) ? int'(bus.latch_q[m_idx]) : 0;
            if (cyc - m_g == S + P + 2) m_act = 0;
        end else begin
            w = rr_pick(bus.req_valid, m_ptr);
            if (w >= 0) begin
                m_act = 1;
                m_g   = cyc;
                m_op  = int'(bus.req_op[w]);
                m_idx = int'(bus.req_idx[w*IW +: IW]);
                m_id  = w;
                m_ptr = (w + 1) % NR;
                m_grants++;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        int d, w;
        logic [NR-1:0] e_ready;
        logic [NL-1:0] sel, e_s, e_r, e_e;
        logic e_done, e_err;
        logic [NR-1:0] e_id;
        if (model_ok) begin
            d = cyc - m_g;
            e_ready = '0;
            if (!m_act) begin
                w = rr_pick(bus.req_valid, m_ptr);
                if (w >= 0) e_ready[w] = 1'b1;
            end
            sel = (m_idx < NL) ? NL'(1 << m_idx) : '0;
            e_s = (m_act && d >= 1 && d <= S + P + 1 && m_op == 1) ? sel : '0;
            e_r = (m_act && d >= 1 && d <= S + P + 1 && m_op == 0) ? sel : '0;
            e_e = (m_act && d >= S + 1 && d <= S + P) ? sel : '0;
            e_done = m_act && d == S + P + 2;
            e_id   = e_done ? NR'(1 << m_id) : '0;
            e_err  = e_done && (m_idx >= NL || m_q != m_op);
            chk("m_ready", int'(bus.req_ready), int'(e_ready));
            chk("m_latch_s", int'(bus.latch_s), int'(e_s));
            chk("m_latch_r", int'(bus.latch_r), int'(e_r));
            chk("m_latch_e", int'(bus.latch_e), int'(e_e));
            chk("m_busy", int'(bus.busy), int'(m_act));
            chk("m_done", int'(bus.done), int'(e_done));
            chk("m_done_id", int'(bus.done_id), int'(e_id));
            chk("m_err", int'(bus.err), int'(e_err));
            chk("inv_s_and_r", int'(|(bus.latch_s & bus.latch_r)), 0);
            chk("inv_one_line", int'($countones(bus.latch_s | bus.latch_r | bus.latch_e) <= 1), 1);
            rdy_seen = bus.req_ready & bus.req_valid;
            if (rdy_seen != '0) begin
                gq.push_back(cyc);
                dut_grants++;
            end
            if (bus.done) begin
                dut_dones++;
                if (gq.size() == 0) chk("done_without_grant", 1, 0);
                else chk("done_latency", cyc - gq.pop_front(), LAT);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Issue one request and follow it to done (bounded).
    task automatic run_one(input int rq, input bit op, input int idx,
                           output int lat, output int er, output int id,
                           output int lines);
        int g;
        g = -1; lat = -1; er = -1; id = -1; lines = 0;
        bus.req_valid[rq]         = 1'b1;
        bus.req_op[rq]            = op;
        bus.req_idx[rq*IW +: IW]  = IW'(idx);
        for (int n = 0; n < 40; n++) begin
            #1;
            lines |= int'(bus.latch_s | bus.latch_r | bus.latch_e);
            if (g < 0 && bus.req_ready[rq]) g = n;
            if (bus.done) begin
                lat = n - g;
                er  = int'(bus.err);
                id  = int'(bus.done_id);
                break;
            end
            tick();
            if (g >= 0) bus.req_valid[rq] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int lat, er, id, lines, ndone;
        int gc[$];
        int gid[$];
        logic [NL-1:0] ss_s [6];
        logic [NL-1:0] ss_e [6];

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_idx   = '0;

        // Reset with random inputs, then idle.
        tick();
        bus.req_valid = NR'($urandom);
        bus.req_op    = NR'($urandom);
        bus.req_idx   = (NR*IW)'($urandom);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("rst_latch_lines", int'(bus.latch_s | bus.latch_r | bus.latch_e), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_done_id", int'(bus.done_id), 0);
        chk("rst_err", int'(bus.err), 0);
        repeat (3) tick();
        chk("idle_ready", int'(bus.req_ready), 0);
        chk("idle_busy", int'(bus.busy), 0);

        // Single set on idx 2: s in cycles 1-4, e in 2-3, done in 5.
        ss_s = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
        ss_e = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
        bus.req_valid = 2'b01;
        bus.req_op    = 2'b01;
        bus.req_idx   = 4'b0010;
        #1;
        chk("ss_ready", int'(bus.req_ready), 1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) bus.req_valid = '0;
            #1;
            chk("ss_latch_s", int'(bus.latch_s), int'(ss_s[c]));
            chk("ss_latch_r", int'(bus.latch_r), 0);
            chk("ss_latch_e", int'(bus.latch_e), int'(ss_e[c]));
            chk("ss_busy", int'(bus.busy), 1);
            chk("ss_done", int'(bus.done), (c == 5) ? 1 : 0);
            chk("ss_done_id", int'(bus.done_id), (c == 5) ? 1 : 0);
            chk("ss_err", int'(bus.err), 0);
        end
        tick();

        // Round-robin: both requesters valid continuously after reset.
        do_reset(1);
        bus.req_op    = 2'b10;
        bus.req_idx   = 4'b0100;
        bus.req_valid = 2'b11;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                gc.push_back(c);
                gid.push_back(bus.req_ready[1] ? 1 : 0);
            end
            tick();
        end
        bus.req_valid = '0;
        chk("rr_count", gc.size(), 4);
        for (int i = 0; i < 4 && i < gc.size(); i++) begin
            chk("rr_cycle", gc[i], 6 * i);
            chk("rr_id", gid[i], i % 2);
        end
        repeat (6) tick();

        // Readback mismatch on a stuck-at-0 latch, then a matching reset on it.
        stuck = 3'b010;
        run_one(0, 1'b1, 1, lat, er, id, lines);
        chk("stuck_set_latency", lat, LAT);
        chk("stuck_set_err", er, 1);
        chk("stuck_set_id", id, 1);
        tick();
        run_one(0, 1'b0, 1, lat, er, id, lines);
        chk("stuck_reset_err", er, 0);
        tick();
        stuck = '0;

        // Out-of-range index: no latch line ever asserted, err set.
        run_one(1, 1'b1, 3, lat, er, id, lines);
        chk("oor_lines", lines, 0);
        chk("oor_latency", lat, LAT);
        chk("oor_err", er, 1);
        chk("oor_id", id, 2);
        tick();

        // Reset in cycle 2 (PULSE): pointer had advanced to 1 before reset.
        bus.req_valid = 2'b01;
        bus.req_op    = 2'b01;
        bus.req_idx   = 4'b0000;
        #1;
        chk("abort_grant", int'(bus.req_ready), 1);
        tick();
        bus.req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_pulse_e", int'(bus.latch_e), 1);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_e_cleared", int'(bus.latch_e), 0);
        chk("abort_busy", int'(bus.busy), 0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            #1;
            ndone += int'(bus.done);
        end
        chk("abort_no_done", ndone, 0);
        bus.req_valid = 2'b11;
        #1;
        chk("abort_ptr_reset", int'(bus.req_ready), 1);
        tick();
        bus.req_valid = '0;
        repeat (8) tick();

        // Random sweep with held-until-granted requests and rare withdrawal.
        stuck      = 3'b010;
        dut_grants = 0;
        dut_dones  = 0;
        m_grants   = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (rdy_seen[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bus.req_valid[i]        = 1'b1;
                        bus.req_op[i]           = 1'($urandom);
                        bus.req_idx[i*IW +: IW] = IW'($urandom_range(0, 3));
                    end
                end else if (!rdy_seen[i] && $urandom_range(0, 49) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            tick();
        end
        bus.req_valid = '0;
        repeat (12) tick();
        chk("sweep_done_eq_grant", dut_dones, dut_grants);
        chk("sweep_model_grants", m_grants, dut_grants);
        chk("sweep_activity", int'(dut_dones > 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_latch_bank_ctrl.md
# sr_latch_bank_ctrl

Sequencing and arbitration controller for a bank of gated SR latches. Accepts set/reset requests from several requesters, grants one at a time round-robin, and drives the addressed latch's s/r/e inputs through a setup, enable-pulse and hold sequence. It then reads the latch's q back and reports completion, with an error flag when q does not match the requested value. The controller guarantees the latch bank never sees s and r asserted together and never has more than one latch enabled.

## Interface
Parameters:
- N_LATCH, 4: number of latches in the bank; must be >= 2.
- N_REQ, 2: number of requesters; must be >= 1.
- SETUP_CYC, 1: cycles s/r are held before enable; must be >= 1.
- PULSE_CYC, 2: cycles enable is asserted; must be >= 1.
- IDXW, clog2(N_LATCH): latch index width (derived).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  N_REQ  per-requester request.
- req_op  in  N_REQ  per-requester operation; 1 = set, 0 = reset.
- req_idx  in  N_REQ*IDXW  per-requester latch index; requester i uses bits [i*IDXW +: IDXW].
- req_ready  out  N_REQ  one-hot grant; the request is accepted in the cycle ready=1.
- latch_s  out  N_LATCH  set inputs to the latch bank.
- latch_r  out  N_LATCH  reset inputs to the latch bank.
- latch_e  out  N_LATCH  enable inputs to the latch bank.
- latch_q  in  N_LATCH  q outputs read back from the latch bank.
- busy  out  1  high whenever the controller is not in IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  N_REQ  one-hot id of the completed requester; valid only while done=1, otherwise 0.
- err  out  1  valid only while done=1: q mismatch or out-of-range index.

## Operation
States: IDLE -> SETUP -> PULSE -> HOLD -> CHECK -> IDLE.

IDLE
- The arbiter selects the first req_valid bit at or after the priority pointer, wrapping around.
- req_ready for the winner is combinational (req_valid & IDLE & win). All other req_ready bits are 0.
- On the grant edge the controller captures op, idx and the winner id. The pointer moves to winner+1 mod N_REQ.
- If no request is valid, the controller stays in IDLE and the pointer is unchanged.

SETUP (SETUP_CYC cycles)
- latch_s[idx] = op and latch_r[idx] = ~op.
- All latch_e bits are 0.

PULSE (PULSE_CYC cycles)
- s/r are held as in SETUP.
- latch_e[idx] = 1.

HOLD (1 cycle)
- latch_e is 0; s/r are still held.
- latch_q[idx] is registered at the end of this cycle.

CHECK (1 cycle)
- All latch outputs are 0.
- done = 1, done_id = captured winner.
- err = (sampled q != op), or 1 if idx was out of range.

Out-of-range idx (idx >= N_LATCH)
- The request is accepted and runs the full sequence with all latch outputs 0.
- It completes with err = 1.

Invariants, checked every cycle
- Never latch_s[k] & latch_r[k].
- At most one bit set across latch_s | latch_r | latch_e.
- latch_e is high only in PULSE.

Requester rules
- Requesters must hold valid/op/idx stable until granted.
- Dropping valid before the grant withdraws the request without side effects.

## Timing
Reset
- On a rst edge: state = IDLE, pointer = 0.
- All outputs read 0 in the following cycle: req_ready (given IDLE), latch_s/r/e, busy, done, done_id, err.
- rst in any state aborts the operation. No done is produced for it, and latch outputs drop to 0 on that edge.

Latency, with the grant in cycle 0
- SETUP: cycles 1..SETUP_CYC.
- PULSE: the next PULSE_CYC cycles.
- HOLD: one cycle; CHECK (done) in cycle SETUP_CYC+PULSE_CYC+2.
- Next grant is possible in cycle SETUP_CYC+PULSE_CYC+3.
- Defaults: SETUP cycle 1, PULSE cycles 2-3, HOLD cycle 4, done in cycle 5, next grant in cycle 6.

Other timing rules
- busy = 1 from cycle 1 through the CHECK cycle inclusive.
- Requests arriving while busy wait; no queueing beyond the requesters' own held valid.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order.

## Test plan
- Reset then idle: rst=1 for 2 cycles with random inputs, then no requests -> all outputs 0, busy=0, no done.
- Single set, defaults: req 0 valid, op=1, idx=2, latch model reset; granted cycle 0 ->
  - latch_s[2]=1 in cycles 1-4;
  - latch_e[2]=1 in cycles 2-3 only;
  - done=1, done_id=01, err=0 in cycle 5.
- Round-robin contention: both requesters valid continuously (N_REQ=2) -> grants alternate 0,1,0,1 every 6 cycles; the pointer wraps correctly.
- Readback mismatch: stuck-at-0 latch model, set idx 1 -> done with err=1. Out-of-range idx (N_LATCH=3, idx=3) -> no latch output ever asserted, done with err=1.
- Reset mid-PULSE: rst in cycle 2 -> latch_e all 0 from cycle 3, no done ever; the next request is granted with pointer = 0.
- Invariant sweep: random requests with SETUP_CYC=2, PULSE_CYC=3 for 10k cycles ->
  - no s&r overlap and at most one active latch line;
  - done count equals grant count;
  - each done arrives 7 cycles after its grant.
